// File: rtl/sram_uart_rx_if.sv
// sram_uart_rx_if: SRAM-style responder bus between the crossbar and the RX UART
interface sram_uart_rx_if #(
   parameter int LEN_ADDR = 64
);
   logic [LEN_ADDR-1:0] addra;
   logic [63:0]         dina;
   logic [63:0]         douta;
   logic                ena;
   logic [7:0]          wea;
   modport master (output addra, dina, ena, wea, input douta);
   modport slave (input addra, dina, ena, wea, output douta);
endinterface

// File: rtl/sram_uart_rx.sv
// sram_uart_rx: UART receiver into a FIFO behind an SRAM port; 8N1, or 8E1 when SRAM_UART_RX_PARITY_EN is defined
module sram_uart_rx #(
   parameter int LEN_ADDR   = 64,
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 16
) (
   input logic           clk,
   input logic           rst_n,
   input logic           rxd,
   sram_uart_rx_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLK_DIV);
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;
   state_t state_q, state_d;
   logic          rxd_m, rxd_s;
   logic [CW-1:0] cnt;
   logic [2:0]    bitn;
   logic [7:0]    sh;
   logic          tick, push_req, ferr_set, par_bad;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   count;
   logic          ovr, ferr, perr;
   logic          full, rd, pop, stat_wr, clr, flush, push_ok;
   logic [63:0]   stat;
   logic          unused;
   assign unused = ^{bus.addra, bus.dina};
   // tick marks the sample point: mid start bit in START, one bit time elsewhere
   assign tick = cnt == ((state_q == START) ? CW'(CLK_DIV / 2 - 1) : CW'(CLK_DIV - 1));
   // two-flop synchroniser, idles high so reset never looks like a start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) {rxd_s, rxd_m} <= 2'b11;
      else {rxd_s, rxd_m} <= {rxd_m, rxd};
   end
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else state_q <= state_d;
   end
`ifdef SRAM_UART_RX_PARITY_EN
   logic perr_set;
`endif
   // next state and per-frame events
   always_comb begin
      state_d  = state_q;
      push_req = 1'b0;
      ferr_set = 1'b0;
`ifdef SRAM_UART_RX_PARITY_EN
      perr_set = 1'b0;
`endif
      case (state_q)
         IDLE:  if (!rxd_s) state_d = START;
         START: if (tick) state_d = rxd_s ? IDLE : DATA;
`ifdef SRAM_UART_RX_PARITY_EN
         DATA:  if (tick && bitn == 3'd7) state_d = PAR;
         PAR: if (tick) begin
            state_d  = STOP;
            perr_set = rxd_s ^ (^sh);
         end
`else
         DATA:  if (tick && bitn == 3'd7) state_d = STOP;
`endif
         STOP: if (tick) begin
            state_d  = rxd_s ? IDLE : BRK;
            push_req = rxd_s & ~par_bad;
            ferr_set = ~rxd_s;
         end
         BRK:     if (rxd_s) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // bit timing counter and LSB-first shift register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         bitn <= '0;
         sh   <= '0;
      end else begin
         cnt  <= (state_q == IDLE || tick) ? '0 : cnt + 1'b1;
         bitn <= (state_q != DATA) ? '0 : bitn + {2'b0, tick};
         if (state_q == DATA && tick) sh <= {rxd_s, sh[7:1]};
      end
   end
`ifdef SRAM_UART_RX_PARITY_EN
   // remember a parity miss until the stop bit decides whether to push
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par_bad <= 1'b0;
      else par_bad <= perr_set | (par_bad & (state_q != IDLE));
   end
   // sticky parity error, a new error beats a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perr <= 1'b0;
      else perr <= perr_set | (perr & ~clr);
   end
`else
   assign par_bad = 1'b0;
   assign perr    = 1'b0;
`endif
   assign rd      = bus.ena && bus.wea == 8'd0;
   assign pop     = rd && !bus.addra[3] && count != '0;
   assign stat_wr = bus.ena && bus.wea[0] && bus.addra[3];
   assign clr     = stat_wr && bus.dina[0];
   assign flush   = stat_wr && bus.dina[1];
   assign full    = count == (AW + 1)'(FIFO_DEPTH);
   assign push_ok = push_req && (!full || pop || flush);
   assign stat    = {48'd0, 8'(count), 3'd0, perr, ferr, ovr, full, count != '0};
   // FIFO storage, no reset needed since count gates every read
   always_ff @(posedge clk) begin
      if (push_ok) mem[wp] <= sh;
   end
   // FIFO pointers; a flush snaps rp to wp so a same-cycle push survives
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push_ok) wp <= wp + 1'b1;
         rp    <= flush ? wp : rp + AW'(pop);
         count <= flush ? (AW + 1)'(push_req) : count + (AW + 1)'(push_ok) - (AW + 1)'(pop);
      end
   end
   // sticky overrun and framing flags, set beats clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr  <= 1'b0;
         ferr <= 1'b0;
      end else begin
         ovr  <= (push_req && !push_ok) || (ovr && !clr);
         ferr <= ferr_set || (ferr && !clr);
      end
   end
   // registered read data, held on writes and idle cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus.douta <= '0;
      else if (rd) bus.douta <= bus.addra[3] ? stat : (pop ? {55'd0, 1'b1, mem[rp]} : 64'd0);
   end
endmodule

// File: doc/sram_uart_rx.md
# sram_uart_rx

Receive-side UART peripheral that presents a synchronous SRAM-style responder port. It sits on a crossbar slave port next to the data SRAM and the transmit UART. It deserialises 8N1 frames from `rxd` into a FIFO. The core pops received bytes by reading a 64-bit data word and checks line state through a status word.

## Interface
Parameters:
- `LEN_ADDR`, 64, width of `addra`
- `CLK_DIV`, 16, clock cycles per bit; even, ≥ 4
- `FIFO_DEPTH`, 16, receive FIFO entries; power of two, ≥ 2

Ports:
- `clk`  in  1  single clock; every flop is on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `addra`  in  `LEN_ADDR`  byte address; only `addra[3]` is decoded (0 = DATA, 1 = STAT)
- `dina`  in  64  write data
- `douta`  out  64  read data, registered
- `ena`  in  1  access strobe
- `wea`  in  8  byte write enables; all zero means a read
- `rxd`  in  1  asynchronous serial input, idle high

## Operation
- Input synchroniser: two flops on `rxd`, both reset to 1; the output is `rxd_s`.
- RX FSM states:
  - IDLE: `rxd_s`=0 → START, bit counter cleared.
  - START: at count `CLK_DIV/2-1`, sample `rxd_s`. If 0 → DATA; if 1 (glitch) → IDLE.
  - DATA: sample every `CLK_DIV` cycles, 8 bits, LSB first → STOP.
  - STOP: sample after `CLK_DIV` cycles.
    - `rxd_s`=1: push the byte → IDLE.
    - `rxd_s`=0: set `ferr`, drop the byte → BREAK.
  - BREAK: wait for `rxd_s`=1 → IDLE.
- FIFO push when full: byte dropped, `ovr` set, contents unchanged.
- DATA read (`ena`, `wea`=0, `addra[3]`=0):
  - `douta[7:0]` = head byte, `douta[8]` = 1 when the FIFO was non-empty, other bits 0.
  - The head is popped on the same edge.
  - Read when empty: `douta`=0, no state change.
- STAT read (`addra[3]`=1):
  - bit 0 non-empty, bit 1 full, bit 2 `ovr`, bit 3 `ferr`, bit 4 `perr`.
  - `[15:8]` entry count; other bits 0.
  - No side effects.
- STAT write (`ena`, `wea[0]`=1, `addra[3]`=1):
  - `dina[0]`=1 clears `ovr`, `ferr` and `perr` (write-1-to-clear).
  - `dina[1]`=1 flushes the FIFO.
  - Writes with `wea[0]`=0, and writes to DATA, are ignored; `douta` holds its value.
- Simultaneous push and pop:
  - Both take effect and the count is unchanged.
  - On an empty FIFO the pop sees empty, so `douta`=0, and the new byte remains.
- Simultaneous push-when-full and pop: the pop frees a slot, the byte is stored, and `ovr` is not set.
- Simultaneous flag set and W1C clear: the set wins.
- Flush concurrent with push: the flush clears first, then the push is stored (count = 1).
- `ena`=0: no access, `douta` holds its value.

## Timing
- Read latency is 1 cycle: `douta` is valid on the edge after the `ena` cycle. Back-to-back reads are allowed, one per cycle. There is no stall or backpressure.
- Reset (asynchronous assert, synchronous-safe deassert):
  - `douta`=0, FSM=IDLE, FIFO empty, all flags 0, synchroniser = 1.
  - Reset mid-frame aborts the frame; the partial byte is discarded.
- Push happens at the STOP sample. The byte is visible in STAT count 1 cycle after the push edge.
- Frame length from `rxd` falling edge to push is 2 (sync) + `CLK_DIV/2` + 9·`CLK_DIV` cycles, ±1.
- FIFO pointers are `log2(FIFO_DEPTH)` bits and wrap naturally. The count is `log2(FIFO_DEPTH)+1` bits, saturating at `FIFO_DEPTH`.

## Configuration
- `SRAM_UART_RX_PARITY_EN` defined:
  - Frame is 8E1: an even-parity bit is sampled after bit 7, before STOP.
  - Parity mismatch sets `perr` and drops the byte; the FSM still samples STOP (framing rules apply).
  - Frame length grows by `CLK_DIV`.
- Undefined: 8N1 framing; `perr` is tied to 0.

## Test plan
- Reset: with `rst_n`=0, `douta`=0. After release, a STAT read returns 0.
- Single byte: send 0xA5 8N1 (`CLK_DIV`=16).
  - STAT read → 0x0101.
  - DATA read → 0x1A5 one cycle later.
  - Next DATA read → 0.
- Overflow: send 17 bytes 0x00..0x10 with `FIFO_DEPTH`=16.
  - STAT → bits 1 and 2 set, count 16.
  - 16 DATA reads return 0x100..0x10F.
  - STAT write `dina`=1 clears `ovr`.
- Framing: send 0x3C with the stop bit low, then hold `rxd` low for 20 bit times, then release.
  - `ferr`=1, FIFO empty.
  - No spurious frame is received during the low period.
- Glitch and concurrency:
  - A 3-cycle low pulse on `rxd` produces no push.
  - A DATA read on the exact push edge with an empty FIFO returns 0 and leaves count 1.
- Parity (with `SRAM_UART_RX_PARITY_EN`):
  - 0x07 with parity bit 1 → accepted.
  - 0x07 with parity bit 0 → `perr`=1, not stored.
